inst_fetch_queue: RTL
=====================

# inst_fetch_queue

Parametrised instruction fetch queue between the IF stage (PC + INSTMEM) and the IF/ID boundary of the 5-stage MIPS pipeline. It is the successor to the single-entry IF/ID latch: it buffers up to DEPTH fetched {pc_4, inst} pairs with valid/ready handshakes on both sides. A hazard-unit flush drops all buffered entries in one cycle. An optional bypass mode gives zero-latency pass-through when the queue is empty.

## Interface
- DATA_W, 32, instruction width
- ADDR_W, 32, width of the pc_4 field
- DEPTH, 4, number of entries; power of two, ≥ 2
- BYPASS, 0, 0 = registered output only, 1 = combinational pass-through when empty
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, synchronous and active-high
- flush  input  1  redirect from the hazard unit; discards all entries
- in_valid  input  1  IF presents a fetched instruction
- in_ready  output  1  queue accepts; equals !full
- in_pc_4  input  ADDR_W  pc+4 of the fetched instruction
- in_inst  input  DATA_W  fetched instruction
- out_valid  output  1  head entry is valid for ID
- out_ready  input  1  ID consumes the head; driven by !stall
- out_pc_4  output  ADDR_W  pc+4 of the head entry
- out_inst  output  DATA_W  head instruction
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- afull  output  1  count ≥ DEPTH-1; lets the PC hold one cycle early

## Operation
- Storage: circular buffer with DEPTH entries of {pc_4, inst}, written at wr_ptr and read at rd_ptr. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Enqueue fires when in_valid & in_ready: the entry is written at wr_ptr, then wr_ptr increments.
- Dequeue fires when out_valid & out_ready: rd_ptr increments.
- Count update: +1 on enqueue only, -1 on dequeue only, unchanged when both fire.
- Full (count == DEPTH): in_ready = 0, even if a dequeue fires in the same cycle. This avoids a combinational ready path from ID back to IF.
- Empty (count == 0), BYPASS = 0: out_valid = 0.
- Empty, BYPASS = 1: out_valid = in_valid, and out_* come directly from in_*. If out_ready is also high, the word passes through and is not stored, so count stays 0.
- Flush: the next state is count = 0, wr_ptr = rd_ptr = 0. Any enqueue or dequeue in the flush cycle is ignored. With BYPASS = 1, out_valid is forced to 0 during a flush cycle.
- Priority: rst > flush > enqueue/dequeue.
- Storage contents are not reset. Only the pointers and count are.
- Outputs: out_pc_4 and out_inst are don't-care while out_valid = 0. The bench must not check them.

## Timing
- Reset: count = 0, out_valid = 0, in_ready = 1, afull = 0, both pointers 0. All take effect on the first edge with rst = 1.
- Reset mid-operation: every in-flight entry is lost. The cycle after reset deasserts behaves as empty.
- Latency, BYPASS = 0: an enqueue at edge N gives out_valid = 1 in cycle N+1.
- Latency, BYPASS = 1: zero latency when empty; otherwise the same as BYPASS = 0.
- Throughput: one enqueue and one dequeue per cycle at any occupancy 1..DEPTH-1.
- Flush at edge N: out_valid = 0 in cycle N+1, except with BYPASS = 1 when a new in_valid arrives in that cycle.
- Flush and rst are sampled only at clock edges. There is no combinational path from them to in_ready.
- Combinational paths:
  - in_ready depends only on registered count.
  - out_valid depends only on registered count, plus in_valid/flush when BYPASS = 1.

## Structure
- Shared package/header (alongside the pipeline wire header) holds:
  - FETCH_DATA_W and FETCH_ADDR_W defaults.
  - The entry layout {pc_4, inst} as a named packed type or concatenation macro, so IF, ID and the queue agree.
- One sub-module, fetch_queue_ram: a DEPTH × (ADDR_W+DATA_W) register array with a synchronous write port and an asynchronous read port.
- Pointer, count and bypass logic live in inst_fetch_queue.
- Parameter checks: elaboration error if DEPTH is not a power of two or is less than 2.

## Test plan
- Reset/fill:
  - Stimulus: rst for 2 cycles, then 4 enqueues with inst = 0x20080001..0x20080004, pc_4 = 0x4..0x10, out_ready = 0.
  - Required: count = 1,2,3,4; afull rises at count 3; in_ready = 0 at count 4; a 5th in_valid is not accepted.
- Drain order:
  - Stimulus: from full, out_ready = 1 for 4 cycles.
  - Required: out_inst = 0x20080001..0x20080004 in order; out_valid = 0 after the last; count = 0.
- Simultaneous enq/deq with wrap:
  - Stimulus: at count 2, enqueue and dequeue together for 6 cycles.
  - Required: count stays 2; pointers wrap past 3 → 0; FIFO order preserved.
- Flush:
  - Stimulus: at count 3, flush = 1 together with in_valid = 1 and out_ready = 1.
  - Required: next cycle count = 0, out_valid = 0; the flushed-cycle input never appears at the output.
- Bypass:
  - Stimulus: BYPASS = 1, empty queue, in_valid = 1 with inst = 0x8C090000 and out_ready = 1.
  - Required: out_inst = 0x8C090000 in the same cycle; count remains 0.
  - Stimulus: repeat with out_ready = 0.
  - Required: the entry is stored; count = 1; the next cycle presents the same word.
- Reset mid-operation:
  - Stimulus: rst = 1 at count 2 while in_valid and out_ready are high.
  - Required: count = 0 and out_valid = 0 the next cycle; no stale data is observed afterwards.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-path types: default field widths and the {pc_4, inst} entry layout
// used by IF, ID and the fetch queue.
package inst_fetch_queue_pkg;

    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_ADDR_W = 32;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc_4;
        logic [FETCH_DATA_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch queue handshake bundle: IF-side enqueue channel and ID-side dequeue channel.
// master = pipeline stages around the queue, slave = the queue itself.
interface inst_fetch_queue_if
    import inst_fetch_queue_pkg::*;
#(
    parameter int DATA_W = FETCH_DATA_W,
    parameter int ADDR_W = FETCH_ADDR_W
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc_4;
    logic [DATA_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc_4;
    logic [DATA_W-1:0] out_inst;

    modport master (
        output in_valid, in_pc_4, in_inst, out_ready,
        input  in_ready, out_valid, out_pc_4, out_inst
    );

    modport slave (
        input  in_valid, in_pc_4, in_inst, out_ready,
        output in_ready, out_valid, out_pc_4, out_inst
    );
endinterface

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read, no reset.
// latency: write visible after the edge; read is combinational from rd_addr.
module fetch_queue_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/inst_fetch_queue.sv
// IF -> ID instruction queue of DEPTH {pc_4, inst} entries; flush empties it in one cycle.
// latency: 1 cycle (0 when BYPASS and empty); backpressure: in_ready = !full, never from out_ready.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DATA_W = FETCH_DATA_W,
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b0,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    inst_fetch_queue_if.slave    fq,
    output logic [CW-1:0]        count,
    output logic                 afull
);
    localparam int ENT_W = ADDR_W + DATA_W;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("inst_fetch_queue: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic [ENT_W-1:0] rd_dat;
    logic             full;
    logic             empty;
    logic             pass_thru;
    logic             enq;
    logic             deq;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == '0);

    assign fq.in_ready = !full;
    assign count       = count_r;
    assign afull       = (count_r >= CW'(DEPTH - 1));

    // With BYPASS, an empty queue forwards the IF word directly; it is only
    // stored when ID does not take it in the same cycle.
    generate
        if (BYPASS) begin : g_bypass
            assign fq.out_valid = !flush && (!empty || fq.in_valid);
            assign pass_thru    = empty && fq.in_valid && fq.out_ready && !flush;
            assign fq.out_pc_4  = empty ? fq.in_pc_4 : rd_dat[ENT_W-1:DATA_W];
            assign fq.out_inst  = empty ? fq.in_inst : rd_dat[DATA_W-1:0];
        end else begin : g_registered
            assign fq.out_valid = !empty;
            assign pass_thru    = 1'b0;
            assign fq.out_pc_4  = rd_dat[ENT_W-1:DATA_W];
            assign fq.out_inst  = rd_dat[DATA_W-1:0];
        end
    endgenerate

    assign enq = fq.in_valid && !full && !pass_thru && !flush;
    assign deq = fq.out_valid && fq.out_ready && !empty && !flush;

    fetch_queue_ram #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (enq && !rst),
        .wr_addr (wr_ptr),
        .wr_dat  ({fq.in_pc_4, fq.in_inst}),
        .rd_addr (rd_ptr),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule
